sram_mem_ctrl: RTL
==================

# sram_mem_ctrl

Memory-stage responder between the MEM pipeline stage and the off-chip 16-bit SRAM. It accepts 32-bit word read/write requests from the MEM stage, splits each into two 16-bit SRAM accesses and holds `ready` low until the transfer completes. The inverted `ready` feeds the `Freeze` inputs of the pipeline registers (ID/EXE and the others), so this block is the other end of the freeze handshake that those registers obey.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: clock cycles per 16-bit SRAM phase; legal range 1–15.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: write request from MEM stage.
- `rd_en`  in  1: read request from MEM stage.
- `address`  in  32: byte address.
- `write_data`  in  32: write word.
- `read_data`  out  32: read word.
- `ready`  out  1: transaction complete or no request; the pipeline uses `Freeze = ~ready`.
- `sram_dq`  inout  16: SRAM data bus; high-Z unless writing.
- `sram_addr`  out  18: SRAM half-word address.
- `sram_we_n`, `sram_oe_n`  out  1 each: active-low write and output enables.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each: tied 0.

## Operation
- Offset address is `a = address - BASE_ADDR`. The word index is `a[17:2]`. Bits `a[31:18]` and `a[1:0]` are ignored.
- Low half uses `sram_addr = {a[17:2], 1'b0}` and data bits [15:0]. High half uses `{a[17:2], 1'b1}` and data bits [31:16].
- If `wr_en` and `rd_en` are both high, the write wins.
- FSM states are IDLE, LOW, HIGH and DONE.
  - IDLE → LOW when a request is present.
  - LOW → HIGH after `WAIT_CYCLES` cycles.
  - HIGH → DONE after `WAIT_CYCLES` cycles.
  - DONE → IDLE unconditionally.
- A 4-bit phase counter clears on every state change.
- `address`, `write_data` and the request type are captured on the IDLE→LOW edge. Later changes to the inputs are ignored until the next IDLE.
- Read:
  - `sram_oe_n` is 0 in LOW and HIGH.
  - `sram_dq[15:0]` is latched into `read_data[15:0]` on the last LOW cycle.
  - The high half is latched into `read_data[31:16]` on the last HIGH cycle.
- Write:
  - `sram_we_n` is 0 and `sram_dq` is driven with the captured half throughout LOW and HIGH.
  - `read_data` is unchanged.
- `ready = ~(wr_en | rd_en) | (state == DONE)`. This is combinational.
- If a request drops mid-transaction, the transaction still completes.

## Timing
- Reset values:
  - state IDLE, counter 0, `read_data` 0.
  - `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq` high-Z, `sram_addr` 0.
  - `ready` = 1 when there is no request.
- A request first sampled in IDLE at cycle n:
  - LOW for cycles n+1 … n+W.
  - HIGH for cycles n+W+1 … n+2W.
  - DONE at cycle n+2W+1.
- `ready` is low for cycles n … n+2W (2W+1 cycles) and high at n+2W+1.
- `read_data` is valid in DONE and holds until the next read completes.
- The pipeline advances on the DONE→IDLE edge. A new request at n+2W+2 starts again from IDLE.
- Reset asserted mid-transaction:
  - Forces IDLE immediately; `sram_we_n` and `sram_oe_n` go to 1 and `sram_dq` goes high-Z.
  - The partial write is left in SRAM. No completion is signalled.

## Configuration
- Macro: `SRAM_LAST_READ_BUF_EN`.
- Defined: add a one-entry buffer holding word index, data and valid bit.
  - A completed read fills the buffer.
  - A read in IDLE whose index matches a valid entry is a hit. On a hit, `ready` is 1 in the same cycle, `read_data` muxes out the buffer data, and the FSM stays in IDLE.
  - A completed write to the matching index updates the buffer data.
  - Reset clears valid.
- Undefined: there is no buffer. Every read takes the full 2W+1 cycles.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - the SRAM address width (18) and data width (16);
  - the default `BASE_ADDR`.
- Sub-module `sram_read_buf` holds the last-read entry. It is instantiated only under `SRAM_LAST_READ_BUF_EN`.

## Test plan
All scenarios use `WAIT_CYCLES` = 2.
- Write 0xDEADBEEF to 1024 → SRAM half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; `ready` low for 5 cycles, then high for 1.
- Read 1028 with SRAM half-words 2 = 0x5678 and 3 = 0x1234 → `read_data` = 0x12345678 in DONE; `sram_oe_n` low for exactly 4 cycles.
- Both `wr_en` and `rd_en` high at address 1032 with data 0xA5A5_0F0F → write performed; `read_data` unchanged.
- Change `address` to 2000 in cycle n+2 of a read of 1024 → data returned is from word 0.
- Assert `rst` in HIGH of a write → IDLE next edge; `sram_we_n` = 1 and `sram_dq` high-Z immediately; only the low half is written.
- With `SRAM_LAST_READ_BUF_EN` defined:
  - A second read of 1028 → `ready` = 1 in the same cycle with 0x12345678.
  - A write of 0xCAFEF00D to 1028, then a read of 1028 → a hit returning 0xCAFEF00D.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Used by sram_mem_ctrl and sram_read_buf.
package sram_ctrl_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int IDX_W   = SRAM_AW - 2;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;
endpackage

// File: rtl/sram_read_buf.sv
// One-entry last-read buffer: word index, data and valid bit.
// A completed write to the held index keeps the data coherent.
module sram_read_buf
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fill,
    input  logic             i_wr_upd,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_data,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_hit,
    output logic [31:0]      o_data
);
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (i_wr_upd && r_valid && (r_idx == i_idx)) begin
            r_data  <= i_data;
        end
    end

    assign o_hit  = r_valid && (r_idx == i_lookup_idx);
    assign o_data = r_data;
endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder: splits 32-bit requests into two 16-bit SRAM phases and
// holds ready low until done. Optional last-read buffer: SRAM_LAST_READ_BUF_EN.
//
// state   | meaning
// IDLE    | no transfer; captures request, address and data
// LOW     | low half-word access, WAIT_CYCLES cycles
// HIGH    | high half-word access, WAIT_CYCLES cycles
// DONE    | ready high for one cycle, read_data valid
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_is_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic               r_drive;
    logic [SRAM_DW-1:0] r_dq_out;

    logic [IDX_W-1:0]   w_idx;
    logic               w_req;
    logic               w_last;
    logic               w_hit;

    // Offset bits above the SRAM range and the byte offset are dropped here.
    assign w_idx  = IDX_W'((address - BASE_ADDR) >> 2);
    assign w_req  = wr_en | rd_en;
    assign w_last = (r_cnt == LAST_CNT);

`ifdef SRAM_LAST_READ_BUF_EN
    logic        w_buf_hit;
    logic        w_done_edge;
    logic [31:0] w_buf_data;

    assign w_done_edge = (r_state == ST_HIGH) && w_last;

    sram_read_buf u_read_buf (
        .clk          (clk),
        .rst          (rst),
        .i_fill       (w_done_edge && !r_is_wr),
        .i_wr_upd     (w_done_edge && r_is_wr),
        .i_idx        (r_idx),
        .i_data       (r_is_wr ? r_wdata : {sram_dq, r_read_data[15:0]}),
        .i_lookup_idx (w_idx),
        .o_hit        (w_buf_hit),
        .o_data       (w_buf_data)
    );

    assign w_hit     = (r_state == ST_IDLE) && rd_en && !wr_en && w_buf_hit;
    assign read_data = w_hit ? w_buf_data : r_read_data;
`else
    assign w_hit     = 1'b0;
    assign read_data = r_read_data;
`endif

    assign ready     = ~w_req | (r_state == ST_DONE) | w_hit;
    assign sram_dq   = r_drive ? r_dq_out : {SRAM_DW{1'bz}};
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_drive     <= 1'b0;
            r_dq_out    <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 4'd1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_req && !w_hit) begin
                        r_state   <= ST_LOW;
                        r_is_wr   <= wr_en;
                        r_idx     <= w_idx;
                        r_wdata   <= write_data;
                        sram_addr <= SRAM_AW'({w_idx, 1'b0});
                        sram_we_n <= ~wr_en;
                        sram_oe_n <= wr_en;
                        r_drive   <= wr_en;
                        r_dq_out  <= write_data[15:0];
                    end
                end
                ST_LOW: begin
                    if (w_last) begin
                        r_state   <= ST_HIGH;
                        r_cnt     <= '0;
                        sram_addr <= SRAM_AW'({r_idx, 1'b1});
                        r_dq_out  <= r_wdata[31:16];
                        if (!r_is_wr)
                            r_read_data[15:0] <= sram_dq;
                    end
                end
                ST_HIGH: begin
                    if (w_last) begin
                        r_state   <= ST_DONE;
                        r_cnt     <= '0;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        r_drive   <= 1'b0;
                        if (!r_is_wr)
                            r_read_data[31:16] <= sram_dq;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule
